// File: rtl/ahb3_lite_n.sv
// ---------------------------------------------------------------------------
// ahb3_lite_n
//
// Zero-wait-state AHB-Lite (AMBA 3) memory slave. It is backed by a
// word-organised internal memory that is split into four byte-lane arrays.
// Byte, halfword and word transfers are supported, and back-to-back
// NONSEQ/SEQ transfers run at one transfer per cycle.
//
// Optional feature macro: AHB3_LITE_N_ERR_RESP_EN
//   defined   : illegal transfers get the two-cycle ERROR response.
//               An illegal transfer is out of range, misaligned or has
//               hsize > 2.
//   undefined : hreadyout is tied 1 and hresp is tied 0. Illegal writes are
//               dropped and illegal reads return 0.
//
// Parameters:
//   ADDR_WIDTH  haddr width
//   DATA_WIDTH  hwdata/hrdata width (must be 32)
//   MEM_DEPTH   memory depth in 32-bit words (power of two)
//
// Ports:
//   hclk       clock, rising edge
//   hresetn    asynchronous active-low reset
//   hsel       slave select from the decoder
//   haddr      byte address (address phase)
//   hwrite     1 = write, 0 = read (address phase)
//   hsize      0 byte, 1 halfword, 2 word
//   hburst     burst type (ignored)
//   hprot      protection (ignored)
//   htrans     0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
//   hready     global bus ready
//   hwdata     write data (data phase)
//   hrdata     read data (data phase)
//   hreadyout  slave ready
//   hresp      0 OKAY, 1 ERROR
// ---------------------------------------------------------------------------
module ahb3_lite_n #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [1:0]            htrans,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hreadyout,
  output logic                  hresp
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int NBYTES = DATA_WIDTH / 8;

  // Burst and protection attributes carry no meaning for this slave.
  logic unused_attr;
  assign unused_attr = ^{hburst, hprot};

  // ---------------- address phase decode ----------------
  logic             accept;
  logic             size_ok;
  logic             align_ok;
  logic             range_ok;
  logic             legal;
  logic [3:0]       be_addr;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_en;
  logic             rd_clear;

  assign accept   = hsel & hready & htrans[1];
  assign size_ok  = (hsize <= 3'd2);
  assign range_ok = (haddr < ADDR_WIDTH'(MEM_DEPTH * 4));
  assign legal    = size_ok & align_ok & range_ok;
  assign rd_idx   = haddr[IDX_W+1:2];
  assign rd_en    = accept & ~hwrite & legal;

  always_comb begin
    align_ok = 1'b0;
    be_addr  = 4'b0000;
    case (hsize)
      3'd0: begin
        align_ok = 1'b1;
        be_addr  = 4'b0001 << haddr[1:0];
      end
      3'd1: begin
        align_ok = ~haddr[0];
        be_addr  = haddr[1] ? 4'b1100 : 4'b0011;
      end
      3'd2: begin
        align_ok = (haddr[1:0] == 2'b00);
        be_addr  = 4'b1111;
      end
      default: begin
        align_ok = 1'b0;
        be_addr  = 4'b0000;
      end
    endcase
  end

  // ---------------- data phase control register ----------------
  // A pending write is held as a byte-enable mask plus a word index.
  // An all-zero mask means "no write in the data phase". This covers
  // reads, idle cycles and illegal writes alike.
  logic [3:0]       dp_be_reg;
  logic [3:0]       dp_be_next;
  logic [IDX_W-1:0] dp_idx_reg;
  logic [IDX_W-1:0] dp_idx_next;

  assign dp_be_next  = (accept & hwrite & legal) ? be_addr : 4'b0000;
  assign dp_idx_next = rd_idx;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dp_be_reg  <= 4'b0000;
      dp_idx_reg <= '0;
    end else if (hready) begin
      dp_be_reg  <= dp_be_next;
      dp_idx_reg <= dp_idx_next;
    end
  end

  // ---------------- byte-lane memories and read registers ----------------
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      logic [7:0] mem_lane [MEM_DEPTH];
      logic [7:0] rd_byte_reg;
      logic       wr_lane;
      logic       fwd_lane;

      // The write lands on the edge that closes its data phase.
      assign wr_lane = dp_be_reg[gi] & hready;

      // A read of the word being written in this same cycle would see stale
      // memory. Take the lanes being written straight from hwdata instead.
      assign fwd_lane = dp_be_reg[gi] & (dp_idx_reg == rd_idx);

      always_ff @(posedge hclk) begin
        if (wr_lane) begin
          mem_lane[dp_idx_reg] <= hwdata[gi*8 +: 8];
        end
      end

      always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
          rd_byte_reg <= 8'h00;
        end else if (rd_en) begin
          rd_byte_reg <= fwd_lane ? hwdata[gi*8 +: 8] : mem_lane[rd_idx];
        end else if (rd_clear) begin
          rd_byte_reg <= 8'h00;
        end
      end

      assign hrdata[gi*8 +: 8] = rd_byte_reg;
    end
  endgenerate

  // ---------------- response ----------------
`ifdef AHB3_LITE_N_ERR_RESP_EN
  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  // An illegal read leaves hrdata untouched in this build.
  assign rd_clear = 1'b0;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_reg <= ST_OKAY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    hreadyout  = 1'b1;
    hresp      = 1'b0;
    case (state_reg)
      ST_OKAY: begin
        if (accept & ~legal) state_next = ST_ERR1;
      end
      ST_ERR1: begin
        hreadyout  = 1'b0;
        hresp      = 1'b1;
        state_next = ST_ERR2;
      end
      ST_ERR2: begin
        // hready is high here, so a new transfer can start immediately.
        hresp      = 1'b1;
        state_next = (accept & ~legal) ? ST_ERR1 : ST_OKAY;
      end
      default: begin
        state_next = ST_OKAY;
      end
    endcase
  end
`else
  // Illegal reads return zero rather than stale or aliased data.
  assign rd_clear  = accept & ~hwrite & ~legal;
  assign hreadyout = 1'b1;
  assign hresp     = 1'b0;
`endif

endmodule

// File: tb/tb_ahb3_lite_n.sv
// ---------------------------------------------------------------------------
// tb_ahb3_lite_n
//
// Self-checking bench for ahb3_lite_n.
//
// Inputs are driven on the falling edge. Registered outputs are sampled on
// the next falling edge, after the rising edge that processed those inputs.
// Each table row is one bus cycle. It gives the address-phase signals and
// the write data that the following row supplies as hwdata.
// ---------------------------------------------------------------------------
module tb_ahb3_lite_n;

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_BUSY = 2'd1;
  localparam logic [1:0] T_NS   = 2'd2;
  localparam logic [1:0] T_SQ   = 2'd3;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hready;
  logic        hready_drv;
  logic        hready_follow;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  // The bus ready either comes from the bench or follows the slave.
  assign hready = hready_follow ? hreadyout : hready_drv;

  ahb3_lite_n #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MEM_DEPTH (256)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hsel      (hsel),
    .haddr     (haddr),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hburst    (hburst),
    .hprot     (hprot),
    .htrans    (htrans),
    .hready    (hready),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hreadyout (hreadyout),
    .hresp     (hresp)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        rdy;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic s, input logic [1:0] t, input logic r,
                     input logic w, input logic [2:0] z, input logic [31:0] a,
                     input logic [31:0] d, input logic c, input logic [31:0] e);
    vec_t v;
    v.sel = s; v.trans = t; v.rdy = r; v.wr = w; v.size = z;
    v.addr = a; v.wdata = d; v.chk = c; v.exp_rdata = e;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_resp(input string name, input logic er, input logic ep);
    chk({name, " hreadyout"}, {31'd0, hreadyout}, {31'd0, er});
    chk({name, " hresp"}, {31'd0, hresp}, {31'd0, ep});
  endtask

  // Drive one bus cycle at a falling edge. Return at the next falling edge.
  task automatic step(input logic s, input logic [1:0] t, input logic r,
                      input logic w, input logic [2:0] z, input logic [31:0] a,
                      input logic [31:0] d);
    hsel = s; htrans = t; hready_drv = r; hwrite = w; hsize = z;
    haddr = a; hwdata = d;
    @(posedge hclk);
    @(negedge hclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    hresetn = 1'b0; hsel = 1'b0; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd0;
    hburst = 3'b011; hprot = 4'b0011; htrans = T_IDLE; hready_drv = 1'b1;
    hready_follow = 1'b0; hwdata = 32'h0;

    // ---------------- reset ----------------
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    chk("reset hrdata", hrdata, 32'h0);
    chk_resp("reset", 1'b1, 1'b0);

    // ---------------- vector table ----------------
    //   sel  trans   rdy wr size addr          wdata         chk exp
    add(1, T_NS,   1, 1, 2, 32'h00, 32'h13579BDF, 0, 32'h0);
    add(1, T_NS,   1, 1, 2, 32'h10, 32'hDEADBEEF, 0, 32'h0);
    add(0, T_IDLE, 1, 0, 0, 32'h00, 32'h0,        0, 32'h0);
    add(1, T_NS,   1, 0, 2, 32'h10, 32'h0,        1, 32'hDEADBEEF);
    add(1, T_NS,   1, 0, 2, 32'h00, 32'h0,        1, 32'h13579BDF);
    // byte / halfword lanes
    add(1, T_NS,   1, 1, 2, 32'h20, 32'h00000000, 0, 32'h0);
    add(1, T_NS,   1, 1, 0, 32'h22, 32'h00AB0000, 0, 32'h0);
    add(1, T_NS,   1, 1, 1, 32'h20, 32'h00001234, 0, 32'h0);
    add(0, T_IDLE, 1, 0, 0, 32'h00, 32'h0,        0, 32'h0);
    add(1, T_NS,   1, 0, 2, 32'h20, 32'h0,        1, 32'h00AB1234);
    add(1, T_NS,   1, 1, 2, 32'h24, 32'h11111111, 0, 32'h0);
    add(1, T_NS,   1, 1, 0, 32'h27, 32'hCD000000, 0, 32'h0);
    add(1, T_NS,   1, 1, 1, 32'h24, 32'h0000BEEF, 0, 32'h0);
    add(1, T_NS,   1, 0, 2, 32'h24, 32'h0,        1, 32'hCD11BEEF);
    // pipelined INCR4 write, then read back
    add(1, T_NS,   1, 1, 2, 32'h40, 32'h1,        0, 32'h0);
    add(1, T_SQ,   1, 1, 2, 32'h44, 32'h2,        0, 32'h0);
    add(1, T_SQ,   1, 1, 2, 32'h48, 32'h3,        0, 32'h0);
    add(1, T_SQ,   1, 1, 2, 32'h4C, 32'h4,        0, 32'h0);
    add(1, T_NS,   1, 0, 2, 32'h40, 32'h0,        1, 32'h1);
    add(1, T_SQ,   1, 0, 2, 32'h44, 32'h0,        1, 32'h2);
    add(1, T_SQ,   1, 0, 2, 32'h48, 32'h0,        1, 32'h3);
    add(1, T_SQ,   1, 0, 2, 32'h4C, 32'h0,        1, 32'h4);
    // forwarding: word, then a single byte lane
    add(1, T_NS,   1, 1, 2, 32'h50, 32'hCAFEF00D, 0, 32'h0);
    add(1, T_NS,   1, 0, 2, 32'h50, 32'h0,        1, 32'hCAFEF00D);
    add(1, T_NS,   1, 1, 0, 32'h51, 32'h00007700, 0, 32'h0);
    add(1, T_NS,   1, 0, 2, 32'h50, 32'h0,        1, 32'hCAFE770D);
    add(1, T_NS,   1, 1, 2, 32'h60, 32'hA5A5A5A5, 0, 32'h0);
    // no-transfer cycles carrying write attributes and all-ones data
    add(0, T_NS,   1, 1, 2, 32'h10, 32'hFFFFFFFF, 0, 32'h0);
    add(1, T_IDLE, 1, 1, 2, 32'h10, 32'hFFFFFFFF, 0, 32'h0);
    add(1, T_BUSY, 1, 1, 2, 32'h10, 32'hFFFFFFFF, 0, 32'h0);
    add(1, T_NS,   0, 1, 2, 32'h10, 32'hFFFFFFFF, 0, 32'h0);
    add(1, T_NS,   1, 0, 2, 32'h10, 32'h0,        1, 32'hDEADBEEF);
`ifndef AHB3_LITE_N_ERR_RESP_EN
    // illegal transfers without error responses: reads give 0, writes dropped
    add(1, T_NS,   1, 0, 2, 32'h400, 32'h0,       1, 32'h0);
    add(1, T_NS,   1, 0, 2, 32'h10,  32'h0,       1, 32'hDEADBEEF);
    add(1, T_NS,   1, 0, 1, 32'h11,  32'h0,       1, 32'h0);
    add(1, T_NS,   1, 0, 2, 32'h00,  32'h0,       1, 32'h13579BDF);
    add(1, T_NS,   1, 0, 3, 32'h10,  32'h0,       1, 32'h0);
    add(1, T_NS,   1, 1, 2, 32'h410, 32'h77777777, 0, 32'h0);
    add(1, T_NS,   1, 1, 2, 32'h12,  32'h55555555, 0, 32'h0);
    add(1, T_NS,   1, 1, 3, 32'h10,  32'h66666666, 0, 32'h0);
    add(0, T_IDLE, 1, 0, 0, 32'h00,  32'h0,       0, 32'h0);
    add(1, T_NS,   1, 0, 2, 32'h10,  32'h0,       1, 32'hDEADBEEF);
`endif
    add(0, T_IDLE, 1, 0, 0, 32'h00, 32'h0,        0, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].sel, tbl[i].trans, tbl[i].rdy, tbl[i].wr, tbl[i].size,
           tbl[i].addr, (i > 0) ? tbl[i-1].wdata : 32'h0);
      chk_resp($sformatf("vec%0d", i), 1'b1, 1'b0);
      if (tbl[i].chk) chk($sformatf("vec%0d hrdata", i), hrdata, tbl[i].exp_rdata);
      $display("vec %0d sel=%0d trans=%0d wr=%0d size=%0d addr=%08h hrdata=%08h rdy=%0d resp=%0d",
               i, tbl[i].sel, tbl[i].trans, tbl[i].wr, tbl[i].size, tbl[i].addr,
               hrdata, hreadyout, hresp);
    end

    // ---------------- reset during a write data phase ----------------
    step(1, T_NS, 1, 1, 2, 32'h60, 32'h0);
    hsel = 1'b0; htrans = T_IDLE; hwdata = 32'h12345678; hresetn = 1'b0;
    @(posedge hclk);
    @(negedge hclk);
    chk("midreset hrdata", hrdata, 32'h0);
    chk_resp("midreset", 1'b1, 1'b0);
    hresetn = 1'b1;
    step(1, T_NS, 1, 0, 2, 32'h60, 32'h0);
    chk("after abort hrdata", hrdata, 32'hA5A5A5A5);
    $display("seq abort-write addr=00000060 hrdata=%08h", hrdata);

`ifdef AHB3_LITE_N_ERR_RESP_EN
    // ---------------- error responses, hready follows hreadyout ----------------
    hready_follow = 1'b1;
    step(1, T_NS, 1, 0, 2, 32'h400, 32'h0);
    chk_resp("err rd range c1", 1'b0, 1'b1);
    step(1, T_NS, 1, 1, 2, 32'h10, 32'h0);            // not accepted: hready low
    chk_resp("err rd range c2", 1'b1, 1'b1);
    chk("err rd range hrdata", hrdata, 32'hA5A5A5A5);
    step(0, T_IDLE, 1, 0, 0, 32'h0, 32'hFFFFFFFF);
    chk_resp("err rd range done", 1'b1, 1'b0);
    $display("seq error read 00000400 done");

    step(1, T_NS, 1, 0, 1, 32'h01, 32'h0);
    chk_resp("err rd align c1", 1'b0, 1'b1);
    step(0, T_IDLE, 1, 0, 0, 32'h0, 32'h0);
    chk_resp("err rd align c2", 1'b1, 1'b1);
    step(1, T_NS, 1, 0, 2, 32'h10, 32'h0);            // accepted in cycle 2
    chk_resp("after err c2 read", 1'b1, 1'b0);
    chk("after err c2 hrdata", hrdata, 32'hDEADBEEF);
    $display("seq error read 00000001 then read 00000010 hrdata=%08h", hrdata);

    step(1, T_NS, 1, 0, 3, 32'h10, 32'h0);
    chk_resp("err size c1", 1'b0, 1'b1);
    step(0, T_IDLE, 1, 0, 0, 32'h0, 32'h0);
    chk_resp("err size c2", 1'b1, 1'b1);
    chk("err size hrdata", hrdata, 32'hDEADBEEF);
    $display("seq error oversize read done");

    step(1, T_NS, 1, 1, 2, 32'h400, 32'h0);
    chk_resp("err wr range c1", 1'b0, 1'b1);
    step(0, T_IDLE, 1, 0, 0, 32'h0, 32'hFFFFFFFF);
    chk_resp("err wr range c2", 1'b1, 1'b1);
    step(1, T_NS, 1, 1, 2, 32'h12, 32'hFFFFFFFF);
    chk_resp("err wr align c1", 1'b0, 1'b1);
    step(0, T_IDLE, 1, 0, 0, 32'h0, 32'h55555555);
    chk_resp("err wr align c2", 1'b1, 1'b1);
    step(1, T_NS, 1, 0, 2, 32'h00, 32'h55555555);
    chk("err wr range mem", hrdata, 32'h13579BDF);
    step(1, T_NS, 1, 0, 2, 32'h10, 32'h0);
    chk("err wr align mem", hrdata, 32'hDEADBEEF);
    chk_resp("err wr done", 1'b1, 1'b0);
    $display("seq error writes done hrdata=%08h", hrdata);
    hready_follow = 1'b0;
    step(0, T_IDLE, 1, 0, 0, 32'h0, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb3_lite_n.md
# ahb3_lite_n

AHB-Lite (AMBA 3) single-slave memory block: zero-wait-state 32-bit slave backed by an internal word-organised memory, supporting byte/halfword/word transfers and fully pipelined back-to-back accesses. It sits behind the system AHB-Lite decoder/mux, receiving HSEL from the decoder and the global HREADY. It returns HREADYOUT and HRESP to the mux.

## Interface
- ADDR_WIDTH, 32, HADDR width.
- DATA_WIDTH, 32, HWDATA/HRDATA width (fixed 32).
- MEM_DEPTH, 256, memory depth in 32-bit words; valid byte range 0 .. MEM_DEPTH*4-1.

Ports:
- HCLK  in  1  clock; all state updates on rising edge.
- HRESETn  in  1  reset; asynchronous, active-low.
- HSEL  in  1  slave select from decoder.
- HADDR  in  32  byte address (address phase).
- HWRITE  in  1  1 = write, 0 = read (address phase).
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word.
- HBURST  in  3  burst type; accepted, ignored.
- HPROT  in  4  protection; accepted, ignored.
- HTRANS  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- HREADY  in  1  global bus ready.
- HWDATA  in  32  write data (data phase).
- HRDATA  out  32  read data (data phase).
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 OKAY, 1 ERROR.

## Operation
- A transfer is accepted on a rising edge with HSEL=1, HREADY=1 and HTRANS[1]=1. Address, HWRITE and HSIZE are registered into a data-phase control register. IDLE, BUSY and unselected cycles register "no transfer".
- Legal transfer: aligned to HSIZE, HSIZE<=2, HADDR < MEM_DEPTH*4.
- Write, data phase: on the edge that ends the data phase, HWDATA byte lanes selected by HSIZE and the registered HADDR[1:0] are written to word HADDR[ADDR_WIDTH-1:2]. Ordering is little-endian; other bytes are unchanged.
- Read: the full addressed word is registered into HRDATA at the edge accepting the address phase, so it is valid throughout the data phase. For sub-word reads the full word is returned; the master selects the lanes.
- Forwarding: if a read address phase coincides with a write data phase to the same word, HRDATA returns merged data, with the new bytes taken from HWDATA.
- HRDATA holds its last value when no read is in progress.
- HBURST/HPROT have no effect. Bursts are served as independent single transfers.
- Memory contents are not cleared by reset.

## Timing
- Reset values: HRDATA=0, HREADYOUT=1, HRESP=0. Data-phase control register = no transfer.
- Reset asserted mid-transfer aborts the transfer; a pending write is discarded.
- OKAY transfers: zero wait states; HREADYOUT=1 and HRESP=0 throughout.
- Back-to-back NONSEQ/SEQ transfers sustain one transfer per cycle.
- Illegal transfer: two-cycle ERROR response.
  - Cycle 1: HREADYOUT=0, HRESP=1.
  - Cycle 2: HREADYOUT=1, HRESP=1.
  - Memory is not written. HRDATA is unchanged.
- Any transfer presented during error cycle 1 is not accepted (HREADY low). In cycle 2 the master may cancel to IDLE; a transfer accepted there starts normally.
- HSEL=0 or IDLE/BUSY: next cycle is OKAY, zero wait.

## Configuration
- AHB3_LITE_N_ERR_RESP_EN
  - Defined: out-of-range, misaligned and oversize transfers produce the two-cycle ERROR response.
  - Undefined: HRESP is tied 0 and HREADYOUT is tied 1. Illegal writes are dropped. Illegal reads return 0. Out-of-range addresses are not wrapped.

## Test plan
- Reset: hold HRESETn=0 for 2 cycles, release. Outputs must be HRDATA=0, HREADYOUT=1, HRESP=0. Issue no transfer.
- Word write/read: NONSEQ write 0x10 = 0xDEADBEEF, then NONSEQ read 0x10. HRDATA must be 0xDEADBEEF with OKAY and zero wait.
- Byte/halfword lanes: word 0x20 = 0x00000000.
  - Byte write 0x22 with HWDATA=0x00AB0000.
  - Halfword write 0x20 with HWDATA=0x00001234.
  - Word read 0x20 must return 0x00AB1234.
- Pipelined INCR4:
  - Writes to 0x40..0x4C of 1, 2, 3, 4 back-to-back (NONSEQ then SEQ). HREADYOUT stays 1.
  - Immediate read burst returns 1, 2, 3, 4.
  - Write 0x50 followed next cycle by read 0x50 returns the new data via forwarding.
- Error, with macro defined and HREADY driven from HREADYOUT: word read 0x400 (MEM_DEPTH=256) or halfword at 0x01. Response must be (HREADYOUT, HRESP) = (0,1) then (1,1). A write to 0x400 leaves the memory unchanged.
- IDLE/BUSY/HSEL=0 with HWRITE=1 and data 0xFFFFFFFF: memory must be unmodified and response OKAY.
